// File: rtl/sram_bist_ctrl.sv
// Write/read BIST sequencer driving an SRAM-controller request/ready handshake.
// Define SRAM_BIST_ERR_LOG_EN to add a first-mismatch log (err_addr/err_exp/err_got/err_phase).
module sram_bist_ctrl #(
  parameter int DW        = 16,
  parameter int AW        = 18,
  parameter int LAST_ADDR = 2**AW - 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [1:0]    mode,
  output logic          mem,
  output logic          rw,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data_f2s,
  input  logic          ready,
  input  logic [DW-1:0] data_s2f,
  output logic          busy,
  output logic          done,
  output logic          pass_ok,
  output logic [15:0]   err_cnt,
  output logic          phase
`ifdef SRAM_BIST_ERR_LOG_EN
  ,
  output logic [AW-1:0] err_addr,
  output logic [DW-1:0] err_exp,
  output logic [DW-1:0] err_got,
  output logic          err_phase
`endif
);

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, CMP, DONE
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(LAST_ADDR);

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          phase_q, phase_d;
  logic [1:0]    mode_q, mode_d;
  logic [15:0]   err_cnt_q, err_cnt_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          wait_first_q, wait_first_d;
  logic [DW-1:0] exp_data;
  logic          run_start;
  logic          cmp_miss;

  function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a,
                                            input logic [1:0]    m,
                                            input logic          ph);
    logic [DW-1:0] p;
    p = '0;
    case (m)
      2'd1: begin
        for (int i = 1; i < DW; i += 2) p[i] = 1'b1;
        if (a[0]) p = ~p;
      end
      2'd2:    p = '0;
      default: p = DW'(a);
    endcase
    return ph ? ~p : p;
  endfunction

  assign exp_data  = pattern(addr_q, mode_q, phase_q);
  assign run_start = ((state_q == IDLE) || (state_q == DONE)) && start && !abort;
  assign cmp_miss  = (state_q == CMP) && (rdata_q != exp_data);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      phase_q      <= 1'b0;
      mode_q       <= 2'd0;
      err_cnt_q    <= 16'd0;
      rdata_q      <= '0;
      wait_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      phase_q      <= phase_d;
      mode_q       <= mode_d;
      err_cnt_q    <= err_cnt_d;
      rdata_q      <= rdata_d;
      wait_first_q <= wait_first_d;
    end
  end

  // NOTE: every variable gets a default before the case so no path infers a latch.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    phase_d      = phase_q;
    mode_d       = mode_q;
    err_cnt_d    = err_cnt_q;
    rdata_d      = rdata_q;
    wait_first_d = 1'b0;

    if (busy && abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (run_start) begin
            state_d   = WR_REQ;
            addr_d    = '0;
            phase_d   = 1'b0;
            mode_d    = mode;
            err_cnt_d = 16'd0;
          end
        end
        WR_REQ: begin
          if (ready) begin
            state_d      = WR_WAIT;
            wait_first_d = 1'b1;
          end
        end
        // The controller still shows the pre-accept ready in the first wait cycle.
        WR_WAIT: begin
          if (!wait_first_q && ready) begin
            if (addr_q < LAST) begin
              addr_d  = addr_q + AW'(1);
              state_d = WR_REQ;
            end else begin
              addr_d  = '0;
              state_d = RD_REQ;
            end
          end
        end
        RD_REQ: begin
          if (ready) begin
            state_d      = RD_WAIT;
            wait_first_d = 1'b1;
          end
        end
        RD_WAIT: begin
          if (!wait_first_q && ready) begin
            rdata_d = data_s2f;
            state_d = CMP;
          end
        end
        CMP: begin
          if (cmp_miss && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
          if (addr_q < LAST) begin
            addr_d  = addr_q + AW'(1);
            state_d = RD_REQ;
          end else if (!phase_q) begin
            phase_d = 1'b1;
            addr_d  = '0;
            state_d = WR_REQ;
          end else begin
            state_d = DONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign mem      = ready && ((state_q == WR_REQ) || (state_q == RD_REQ));
  assign rw       = (state_q != WR_REQ);
  assign addr     = addr_q;
  assign data_f2s = (state_q == WR_REQ) ? exp_data : '0;
  assign busy     = (state_q != IDLE) && (state_q != DONE);
  assign done     = (state_q == DONE);
  assign pass_ok  = done && (err_cnt_q == 16'd0);
  assign err_cnt  = err_cnt_q;
  assign phase    = phase_q;

`ifdef SRAM_BIST_ERR_LOG_EN
  logic [AW-1:0] err_addr_q;
  logic [DW-1:0] err_exp_q;
  logic [DW-1:0] err_got_q;
  logic          err_phase_q;

  // A zero error count before this compare marks the first mismatch of the run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_addr_q  <= '0;
      err_exp_q   <= '0;
      err_got_q   <= '0;
      err_phase_q <= 1'b0;
    end else if (run_start) begin
      err_addr_q  <= '0;
      err_exp_q   <= '0;
      err_got_q   <= '0;
      err_phase_q <= 1'b0;
    end else if (cmp_miss && !abort && (err_cnt_q == 16'd0)) begin
      err_addr_q  <= addr_q;
      err_exp_q   <= exp_data;
      err_got_q   <= rdata_q;
      err_phase_q <= phase_q;
    end
  end

  assign err_addr  = err_addr_q;
  assign err_exp   = err_exp_q;
  assign err_got   = err_got_q;
  assign err_phase = err_phase_q;
`endif

endmodule

// File: tb/tb_sram_bist_ctrl.sv
// Directed bench for sram_bist_ctrl: main instance (16 words) plus a LAST_ADDR=0 instance,
// each behind a behavioural SRAM-controller model with configurable ready latency and read faults.
module tb_sram_bist_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic [1:0]  mode;

  logic        mem, rw, ready, busy, done, pass_ok, phase;
  logic [3:0]  addr;
  logic [15:0] data_f2s, err_cnt;
  logic [15:0] data_s2f = '0;

  logic        mem0, rw0, ready0, busy0, done0, pass_ok0, phase0;
  logic [3:0]  addr0;
  logic [15:0] data_f2s0, err_cnt0;
  logic [15:0] data_s2f0 = '0;
  logic [15:0] word0 = '0;

`ifdef SRAM_BIST_ERR_LOG_EN
  logic [3:0]  err_addr, err_addr0;
  logic [15:0] err_exp, err_got, err_exp0, err_got0;
  logic        err_phase, err_phase0;
`endif

  int total = 0;
  int bad   = 0;

  logic [15:0] sram [16];
  int          lat        = 1;
  int          hold       = 0;
  bit          stall      = 1'b0;
  bit          fault_en   = 1'b0;
  bit          fault_any  = 1'b0;
  logic [3:0]  fault_addr = '0;
  logic [15:0] fault_mask = '0;
  int          req_cnt    = 0;
  int          viol_cnt   = 0;
  logic        mem_prev   = 1'b0;
  int          wr0_cnt    = 0;
  int          rd0_cnt    = 0;
  int          viol0_cnt  = 0;

  always #5 clk = ~clk;

  sram_bist_ctrl #(.DW(16), .AW(4), .LAST_ADDR(15)) u_dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode),
    .mem(mem), .rw(rw), .addr(addr), .data_f2s(data_f2s),
    .ready(ready), .data_s2f(data_s2f),
    .busy(busy), .done(done), .pass_ok(pass_ok), .err_cnt(err_cnt), .phase(phase)
`ifdef SRAM_BIST_ERR_LOG_EN
    , .err_addr(err_addr), .err_exp(err_exp), .err_got(err_got), .err_phase(err_phase)
`endif
  );

  sram_bist_ctrl #(.DW(16), .AW(4), .LAST_ADDR(0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode),
    .mem(mem0), .rw(rw0), .addr(addr0), .data_f2s(data_f2s0),
    .ready(ready0), .data_s2f(data_s2f0),
    .busy(busy0), .done(done0), .pass_ok(pass_ok0), .err_cnt(err_cnt0), .phase(phase0)
`ifdef SRAM_BIST_ERR_LOG_EN
    , .err_addr(err_addr0), .err_exp(err_exp0), .err_got(err_got0), .err_phase(err_phase0)
`endif
  );

  // Controller model: accepts on mem&ready, drops ready for lat cycles, read data valid when ready returns.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready <= 1'b1;
      hold  <= 0;
    end else if (mem && ready) begin
      if (!rw) sram[addr] <= data_f2s;
      else if (fault_en && (fault_any || addr == fault_addr)) data_s2f <= sram[addr] & ~fault_mask;
      else data_s2f <= sram[addr];
      ready <= 1'b0;
      hold  <= lat - 1;
    end else if (!ready && !stall) begin
      if (hold == 0) ready <= 1'b1;
      else hold <= hold - 1;
    end
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready0 <= 1'b1;
    end else if (mem0 && ready0) begin
      if (!rw0) word0 <= data_f2s0;
      else data_s2f0 <= word0;
      ready0 <= 1'b0;
    end else begin
      ready0 <= 1'b1;
    end
  end

  always @(posedge clk) begin
    if (mem && ready) req_cnt <= req_cnt + 1;
    if (mem0 && ready0) begin
      if (rw0) rd0_cnt <= rd0_cnt + 1;
      else wr0_cnt <= wr0_cnt + 1;
    end
  end

  // Protocol monitor: a request while ready is low, or a request held two cycles.
  always @(negedge clk) begin
    if (mem && (!ready || mem_prev)) viol_cnt <= viol_cnt + 1;
    mem_prev <= mem;
    if (mem0 && addr0 != 4'd0) viol0_cnt <= viol0_cnt + 1;
  end

  task automatic pulse_start(input logic [1:0] m);
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_req(input int base, input int n, input bit need_mem, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ((req_cnt - base == n) && (!need_mem || mem)) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'd0;
    #1;
    total++;
    if ({mem, rw, busy, done, pass_ok, phase} !== 6'b010000) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 010000", {mem, rw, busy, done, pass_ok, phase});
    end
    total++;
    if ({addr, data_f2s, err_cnt} !== 36'h0) begin
      bad++;
      $display("FAIL reset_data: got %h want 0", {addr, data_f2s, err_cnt});
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ideal_run;
    int base, vbase;
    bit to;
    fault_en = 1'b0; lat = 1;
    base = req_cnt; vbase = viol_cnt;
    pulse_start(2'd0);
    total++;
    if ({busy, done, phase, addr} !== {3'b100, 4'd0}) begin
      bad++;
      $display("FAIL ideal_entry: got %b want 1000000", {busy, done, phase, addr});
    end
    wait_done(2000, to);
    total++;
    if (to) begin bad++; $display("FAIL ideal_timeout: done never rose"); end
    total++;
    if ({done, pass_ok, busy, phase, err_cnt} !== {4'b1101, 16'd0}) begin
      bad++;
      $display("FAIL ideal_status: got %h want %h", {done, pass_ok, busy, phase, err_cnt}, {4'b1101, 16'd0});
    end
    total++;
    if (req_cnt - base != 64) begin bad++; $display("FAIL ideal_reqs: got %0d want 64", req_cnt - base); end
    total++;
    if (sram[7] !== 16'hFFF8) begin bad++; $display("FAIL ideal_word7: got %h want fff8", sram[7]); end
    total++;
    if (viol_cnt != vbase) begin bad++; $display("FAIL ideal_protocol: got %0d violations want 0", viol_cnt - vbase); end
`ifdef SRAM_BIST_ERR_LOG_EN
    total++;
    if ({err_addr, err_exp, err_got, err_phase} !== 37'h0) begin
      bad++;
      $display("FAIL ideal_log_clear: got %h want 0", {err_addr, err_exp, err_got, err_phase});
    end
`endif
    repeat (5) @(negedge clk);
    total++;
    if ({done, pass_ok, busy} !== 3'b110) begin bad++; $display("FAIL done_held: got %b want 110", {done, pass_ok, busy}); end
  endtask

  task automatic test_mode_held_slow;
    int base, vbase;
    bit to;
    fault_en = 1'b0; lat = 3;
    base = req_cnt; vbase = viol_cnt;
    pulse_start(2'd1);
    mode = 2'd2;
    total++;
    if (data_f2s !== 16'hAAAA) begin bad++; $display("FAIL mode1_first_write: got %h want aaaa", data_f2s); end
    wait_done(3000, to);
    total++;
    if (to || !pass_ok || err_cnt !== 16'd0) begin
      bad++;
      $display("FAIL mode1_slow_status: timeout=%0d pass_ok=%b err_cnt=%0d want 0 1 0", to, pass_ok, err_cnt);
    end
    total++;
    if (req_cnt - base != 64) begin bad++; $display("FAIL mode1_reqs: got %0d want 64", req_cnt - base); end
    total++;
    if (viol_cnt != vbase) begin bad++; $display("FAIL mode1_protocol: got %0d violations want 0", viol_cnt - vbase); end
    total++;
    if ({sram[0], sram[1]} !== 32'h5555AAAA) begin
      bad++;
      $display("FAIL mode_held: got %h %h want 5555 aaaa", sram[0], sram[1]);
    end
    lat = 1;
  endtask

  task automatic run_fault(input string name, input logic [1:0] m, input bit any, input logic [3:0] fa,
                           input logic [15:0] fm, input logic [15:0] exp_cnt, input logic [36:0] exp_log);
    bit to;
    fault_en = 1'b1; fault_any = any; fault_addr = fa; fault_mask = fm; lat = 1;
    pulse_start(m);
    wait_done(2000, to);
    total++;
    if (to || {done, pass_ok} !== 2'b10 || err_cnt !== exp_cnt) begin
      bad++;
      $display("FAIL %s: timeout=%0d done,pass_ok=%b err_cnt=%0d want 0 10 %0d", name, to, {done, pass_ok}, err_cnt, exp_cnt);
    end
`ifdef SRAM_BIST_ERR_LOG_EN
    total++;
    if ({err_addr, err_exp, err_got, err_phase} !== exp_log) begin
      bad++;
      $display("FAIL %s_log: got %h want %h", name, {err_addr, err_exp, err_got, err_phase}, exp_log);
    end
`else
    if (exp_log[36:33] > 4'd15) $display("unused log expectation");
`endif
    fault_en = 1'b0;
  endtask

  task automatic test_abort;
    int base;
    bit to;
    base = req_cnt;
    pulse_start(2'd0);
    wait_req(base, 9, 1'b1, to);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++;
    if (to || {busy, done, pass_ok} !== 3'b000 || err_cnt !== 16'd0) begin
      bad++;
      $display("FAIL abort_status: timeout=%0d busy,done,pass_ok=%b err_cnt=%0d want 0 000 0", to, {busy, done, pass_ok}, err_cnt);
    end
    total++;
    if (req_cnt - base != 10) begin bad++; $display("FAIL abort_reqs: got %0d want 10", req_cnt - base); end
    repeat (3) @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL abort_beats_start: busy got %b want 0", busy); end
    pulse_start(2'd0);
    wait_done(2000, to);
    total++;
    if (to || !pass_ok || err_cnt !== 16'd0) begin
      bad++;
      $display("FAIL rerun_after_abort: timeout=%0d pass_ok=%b err_cnt=%0d want 0 1 0", to, pass_ok, err_cnt);
    end
  endtask

  task automatic test_abort_keeps_errors;
    bit to;
    fault_en = 1'b1; fault_any = 1'b1; fault_mask = 16'h0001;
    pulse_start(2'd0);
    to = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (phase) begin to = 1'b0; break; end
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++;
    if (to || {busy, done, pass_ok} !== 3'b000 || err_cnt !== 16'd8) begin
      bad++;
      $display("FAIL abort_keeps_errors: timeout=%0d busy,done,pass_ok=%b err_cnt=%0d want 0 000 8", to, {busy, done, pass_ok}, err_cnt);
    end
`ifdef SRAM_BIST_ERR_LOG_EN
    total++;
    if ({err_addr, err_exp, err_got, err_phase} !== {4'd1, 16'h0001, 16'h0000, 1'b0}) begin
      bad++;
      $display("FAIL abort_log: got %h want %h", {err_addr, err_exp, err_got, err_phase}, {4'd1, 16'h0001, 16'h0000, 1'b0});
    end
`endif
    fault_en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_start_while_busy;
    int base;
    bit to;
    lat = 1;
    base = req_cnt;
    pulse_start(2'd0);
    wait_req(base, 5, 1'b0, to);
    stall = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    total++;
    if (to || {busy, phase, addr} !== {2'b10, 4'd4}) begin
      bad++;
      $display("FAIL start_while_busy: timeout=%0d busy,phase,addr=%b want 0 104", to, {busy, phase, addr});
    end
    stall = 1'b0;
    wait_done(2000, to);
    total++;
    if (to || !pass_ok || req_cnt - base != 64) begin
      bad++;
      $display("FAIL start_while_busy_run: timeout=%0d pass_ok=%b reqs=%0d want 0 1 64", to, pass_ok, req_cnt - base);
    end
  endtask

  task automatic test_reset_mid_read;
    int base;
    bit to;
    lat = 3;
    base = req_cnt;
    pulse_start(2'd0);
    wait_req(base, 20, 1'b0, to);
    total++;
    if (to || {busy, rw, mem, addr} !== {3'b110, 4'd3}) begin
      bad++;
      $display("FAIL pre_reset_read_wait: timeout=%0d busy,rw,mem,addr=%b want 0 1100011", to, {busy, rw, mem, addr});
    end
    reset = 1'b0;
    #1;
    total++;
    if ({mem, rw, busy, done, pass_ok, phase, addr, data_f2s, err_cnt} !== {6'b010000, 36'h0}) begin
      bad++;
      $display("FAIL mid_read_reset: got %h want %h", {mem, rw, busy, done, pass_ok, phase, addr, data_f2s, err_cnt}, {6'b010000, 36'h0});
    end
    @(negedge clk);
    reset = 1'b1;
    lat = 1;
    repeat (4) @(negedge clk);
    total++;
    if ({busy, mem, req_cnt - base} !== {2'b00, 32'd20}) begin
      bad++;
      $display("FAIL no_resume: busy=%b mem=%b reqs=%0d want 0 0 20", busy, mem, req_cnt - base);
    end
  endtask

  task automatic test_last_addr_zero;
    int wb, rb, vb;
    bit to;
    wb = wr0_cnt; rb = rd0_cnt; vb = viol0_cnt;
    pulse_start(2'd0);
    total++;
    if ({busy0, done0} !== 2'b10) begin bad++; $display("FAIL la0_entry: got %b want 10", {busy0, done0}); end
    to = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done0) begin to = 1'b0; break; end
    end
    total++;
    if (to || wr0_cnt - wb != 2 || rd0_cnt - rb != 2 || viol0_cnt != vb) begin
      bad++;
      $display("FAIL la0_accesses: timeout=%0d writes=%0d reads=%0d addr_viol=%0d want 0 2 2 0", to, wr0_cnt - wb, rd0_cnt - rb, viol0_cnt - vb);
    end
    total++;
    if ({pass_ok0, phase0, err_cnt0} !== {2'b11, 16'd0}) begin
      bad++;
      $display("FAIL la0_status: got %h want %h", {pass_ok0, phase0, err_cnt0}, {2'b11, 16'd0});
    end
`ifdef SRAM_BIST_ERR_LOG_EN
    total++;
    if ({err_addr0, err_exp0, err_got0, err_phase0} !== 37'h0) begin
      bad++;
      $display("FAIL la0_log: got %h want 0", {err_addr0, err_exp0, err_got0, err_phase0});
    end
`endif
    wait_done(2000, to);
    total++;
    if (to) begin bad++; $display("FAIL la0_main_timeout: main instance never finished"); end
  endtask

  initial begin
    test_reset();
    test_ideal_run();
    test_mode_held_slow();
    run_fault("single_fault", 2'd0, 1'b0, 4'd5, 16'h0008, 16'd1, {4'd5, 16'hFFFA, 16'hFFF2, 1'b1});
    run_fault("multi_fault", 2'd0, 1'b1, 4'd0, 16'h0001, 16'd16, {4'd1, 16'h0001, 16'h0000, 1'b0});
    run_fault("mode2_fault", 2'd2, 1'b1, 4'd0, 16'h0001, 16'd16, {4'd0, 16'hFFFF, 16'hFFFE, 1'b1});
    test_abort();
    test_abort_keeps_errors();
    test_ideal_run();
    test_start_while_busy();
    test_reset_mid_read();
    test_last_addr_zero();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
